// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter that shares one memory controller FSM among NUM_REQ requesters,
// with a WAIT timeout so a missing valid strobe cannot stall the requesters forever.
module mem_access_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_op,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      mem_select,
   output logic                      mem_op,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_valid,
   input  logic [DATA_W-1:0]         mem_rdata
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   state_t        state;
   logic [IW-1:0] ptr, cur, pick, cand;
   logic [IW:0]   sum;
   logic [CW-1:0] cnt;
   logic          found;
   // first set request at or after the priority pointer, wrapping around
   always_comb begin
      found = 1'b0;
      pick = ptr;
      sum = '0;
      cand = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         cand = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick = cand;
         end
      end
   end
   assign busy = state != S_IDLE;
   assign mem_select = (state == S_ISSUE) || (state == S_WAIT);
   assign ack = (state == S_DONE) ? (NUM_REQ'(1) << cur) : '0;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         ptr <= '0;
         cur <= '0;
         cnt <= '0;
         mem_op <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (found) begin
               cur <= pick;
               mem_op <= req_op[pick];
               mem_addr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
               mem_wdata <= req_wdata[int'(pick)*DATA_W +: DATA_W];
               state <= S_ISSUE;
            end
            S_ISSUE: begin
               cnt <= '0;
               state <= S_WAIT;
            end
            S_WAIT: if (mem_valid) begin
               rsp_rdata <= mem_op ? '0 : mem_rdata;
               rsp_err <= 1'b0;
               state <= S_DONE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               rsp_rdata <= '0;
               rsp_err <= 1'b1;
               state <= S_DONE;
            end else begin
               cnt <= cnt + CW'(1);
            end
            default: begin
               ptr <= (cur == IW'(NUM_REQ - 1)) ? '0 : cur + IW'(1);
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed stimulus with a queue-based scoreboard; a monitor checks every ack
// against the queued expectation, and a small memory model answers after a programmable select count.
module tb_mem_access_arbiter;
   localparam int TO = 16;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] req = '0, req_op = '0, ack;
   logic [7:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [7:0] rsp_rdata, mem_wdata, mem_rdata = '0;
   logic       rsp_err, busy, mem_select, mem_op, mem_valid = 1'b0;
   logic [3:0] mem_addr;
   int checks = 0, failures = 0, acks_seen = 0;
   int resp_at = 0, sel_cnt = 0, last_len = 0;
   logic force_valid = 1'b0;
   typedef struct {
      logic [1:0] ack;
      logic [7:0] rdata;
      logic       err;
      logic [3:0] addr;
      logic       op;
      logic [7:0] wdata;
      int         len;
   } exp_t;
   exp_t sb[$];

   mem_access_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .mem_select(mem_select), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] a, input logic [7:0] rd, input logic e, input logic [3:0] ad,
                       input logic o, input logic [7:0] wd, input int len);
      exp_t x;
      x.ack = a; x.rdata = rd; x.err = e; x.addr = ad; x.op = o; x.wdata = wd; x.len = len;
      sb.push_back(x);
   endtask

   task automatic check_zero(input string name);
      cmp(name, 32'({ack, rsp_rdata, rsp_err, busy, mem_select, mem_op, mem_addr, mem_wdata}), 32'd0);
   endtask

   // counts acks and drops all requests on the last one so no extra grant follows
   task automatic wait_acks(input int n);
      int got = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         @(negedge clk);
         if (ack != 2'b00) begin
            got++;
            if (got == n) req = 2'b00;
         end
      end
      cmp("ack_count", 32'(got), 32'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1 check_zero("reset_state");
      @(negedge clk);
      reset = 1'b1;
   endtask

   // memory model: counts select-high cycles, answers at select cycle resp_at (0 = never)
   initial forever begin
      @(negedge clk);
      if (mem_select) sel_cnt++;
      else begin
         if (sel_cnt != 0) last_len = sel_cnt;
         sel_cnt = 0;
      end
      mem_valid = force_valid || (mem_select && resp_at != 0 && sel_cnt == resp_at);
   end

   initial forever begin
      @(negedge clk);
      #1;
      if (ack !== 2'b00) begin
         acks_seen++;
         if (sb.size() == 0) cmp("unexpected_ack", 32'(ack), 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            cmp("ack", 32'(ack), 32'(e.ack));
            cmp("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            cmp("rsp_err", 32'(rsp_err), 32'(e.err));
            cmp("mem_addr_op_wdata", 32'({mem_addr, mem_op, mem_wdata}), 32'({e.addr, e.op, e.wdata}));
            cmp("select_len", 32'(last_len), 32'(e.len));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      reset = 1'b1;
      // 1: single read, valid in 2nd WAIT cycle
      @(posedge clk); #1;
      req_op = 2'b00; req_addr = 8'h03; req_wdata = 16'h0011; mem_rdata = 8'hA5; resp_at = 3;
      push(2'b01, 8'hA5, 1'b0, 4'h3, 1'b0, 8'h11, 3);
      req = 2'b01;
      wait_acks(1);
      // 2: both requesters write, grants alternate from requester 0
      do_reset();
      @(posedge clk); #1;
      req_op = 2'b11; req_addr = 8'hC5; req_wdata = 16'hC35A; mem_rdata = 8'h3C; resp_at = 2;
      push(2'b01, 8'h00, 1'b0, 4'h5, 1'b1, 8'h5A, 2);
      push(2'b10, 8'h00, 1'b0, 4'hC, 1'b1, 8'hC3, 2);
      push(2'b01, 8'h00, 1'b0, 4'h5, 1'b1, 8'h5A, 2);
      push(2'b10, 8'h00, 1'b0, 4'hC, 1'b1, 8'hC3, 2);
      req = 2'b11;
      wait_acks(4);
      // 3: read that never gets valid times out
      @(posedge clk); #1;
      req_op = 2'b00; req_addr = 8'h90; req_wdata = 16'h0000; mem_rdata = 8'hFF; resp_at = 0;
      push(2'b10, 8'h00, 1'b1, 4'h9, 1'b0, 8'h00, TO + 1);
      req = 2'b10;
      wait_acks(1);
      @(negedge clk); #2;
      cmp("busy_after_timeout", 32'(busy), 32'd0);
      // 4: valid on the last timeout cycle wins
      @(posedge clk); #1;
      req_op = 2'b00; req_addr = 8'h07; mem_rdata = 8'h96; resp_at = TO + 1;
      push(2'b01, 8'h96, 1'b0, 4'h7, 1'b0, 8'h00, TO + 1);
      req = 2'b01;
      wait_acks(1);
      // 5: reset during WAIT aborts with no ack; pointer restarts at requester 0
      @(posedge clk); #1;
      req_op = 2'b00; req_addr = 8'h21; req_wdata = 16'hBBAA; resp_at = 0;
      req = 2'b11;
      repeat (4) @(negedge clk);
      #1 reset = 1'b0;
      #1 check_zero("reset_mid_wait");
      resp_at = 2; mem_rdata = 8'h42;
      push(2'b01, 8'h42, 1'b0, 4'h1, 1'b0, 8'hAA, 2);
      push(2'b10, 8'h42, 1'b0, 4'h2, 1'b0, 8'hBB, 2);
      repeat (2) @(negedge clk);
      check_zero("reset_held");
      reset = 1'b1;
      wait_acks(2);
      // 6: stray valid while idle does nothing
      @(posedge clk); #1;
      force_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #2;
         cmp("idle_busy_select", 32'({busy, mem_select}), 32'd0);
      end
      force_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      cmp("scoreboard_empty", 32'(sb.size()), 32'd0);
      cmp("acks_seen", 32'(acks_seen), 32'd9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
